instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the instruction-memory byte-address width; depth SHALL be 2^(ADDR_W-2) words.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  SHALL request a new load; it SHALL be honoured only in IDLE, DONE or ERR.
REQ-005 in_valid  input  1  SHALL mark a valid byte on in_data.
REQ-006 in_data  input  8  SHALL carry the byte stream.
REQ-007 in_ready  output  1  SHALL indicate that the block accepts a byte this cycle.
REQ-008 imem_we  output  1  SHALL strobe one instruction-memory write.
REQ-009 imem_addr  output  ADDR_W  SHALL give the byte address of the write, always word-aligned.
REQ-010 imem_wdata  output  32  SHALL give the write data.
REQ-011 cpu_rst  output  1  SHALL be the processor reset, active-low; 0 SHALL hold the processor in reset.
REQ-012 busy  output  1  SHALL be high in states LEN_HI, LEN_LO, DATA and WRITE.
REQ-013 done  output  1  SHALL be high in state DONE.
REQ-014 err  output  1  SHALL be high in state ERR.

Function
REQ-015 A byte SHALL transfer only on a cycle where in_valid=1 and in_ready=1; in_ready SHALL be 1 only in LEN_HI, LEN_LO and DATA.
REQ-016 The FSM SHALL have the states IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE and ERR.
REQ-017 On start=1 in IDLE, DONE or ERR, the FSM SHALL go to LEN_HI, clear the address and byte counters, and drive cpu_rst=0 from the next cycle.
REQ-018 In LEN_HI and LEN_LO, the accepted bytes SHALL form a 16-bit word count N, high byte first.
REQ-019 After LEN_LO is accepted, N=0 SHALL go to DONE, N>2^(ADDR_W-2) SHALL go to ERR, and any other N SHALL go to DATA.
REQ-020 In DATA, bytes SHALL assemble big-endian: the first byte SHALL go to [31:24] and the fourth byte to [7:0].
REQ-021 Acceptance of the 4th byte SHALL move the FSM to WRITE, where imem_we=1 for exactly one cycle with the registered address and word.
REQ-022 in_ready SHALL be 0 in WRITE; latency from the 4th-byte handshake to imem_we SHALL be 1 cycle.
REQ-023 After WRITE, imem_addr SHALL increment by 4 and the remaining count SHALL decrement by 1.
REQ-024 After WRITE, the FSM SHALL return to DATA if words remain, and otherwise go to DONE.
REQ-025 imem_addr SHALL never wrap; the length check in REQ-019 guarantees the last address is 2^ADDR_W-4.
REQ-026 In DONE, cpu_rst SHALL be 1 and in_ready SHALL be 0.
REQ-027 In ERR, cpu_rst SHALL be 0 and in_ready SHALL be 0; bytes presented in ERR SHALL be ignored.
REQ-028 start while busy=1 SHALL be ignored.
REQ-029 in_valid gaps of any length SHALL stall the FSM without losing partial-word bytes.
REQ-030 imem_wdata and imem_addr SHALL hold their values when imem_we=0.

Reset
REQ-031 With rst=0 at a clock edge, the FSM SHALL go to IDLE and counters, imem_addr and imem_wdata SHALL become 0.
REQ-032 During and after that reset edge: imem_we=0, in_ready=0, busy=0, done=0, err=0 and cpu_rst=0.
REQ-033 Reset mid-load SHALL abandon the partial word with no further write, and the processor SHALL remain held in reset.
REQ-034 IDLE SHALL be left only by start; the processor SHALL never run without a completed load.

Verification
REQ-035 Reset, then start, then stream 00 02 20 08 00 05 AC 08 00 00 -> writes of 0x20080005 at address 0x000 and 0xAC080000 at address 0x004; done=1; cpu_rst=1.
REQ-036 Count 00 00 -> no imem_we; DONE is entered on the cycle after LEN_LO is accepted; cpu_rst=1.
REQ-037 Count 01 01 (257) with ADDR_W=10 -> ERR; err=1; cpu_rst=0; no writes; a later start recovers and loads correctly.
REQ-038 Count 01 00 (256) with random in_valid gaps -> 256 writes; final imem_addr=0x3FC; no byte lost or duplicated.
REQ-039 rst=0 after 2 data bytes of word 3, then rst=1 -> no further writes; IDLE; all outputs at reset values.
REQ-040 start pulsed during DATA -> ignored; the load completes unchanged.

Source files
------------

// File: rtl/instr_loader.sv
// Byte-stream instruction loader: receives a 16-bit word count followed by big-endian
// words, writes them to instruction memory, then releases the processor from reset.
module instr_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned DEPTH = 1 << (ADDR_W - 2);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         len_hi_q, len_hi_d;
    logic [CNT_W-1:0]   remain_q, remain_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [23:0]        word_q, word_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [31:0]        wdata_d;
    logic [CNT_W-1:0]   len_word;
    logic               xfer;
    logic               in_ready_d, imem_we_d, cpu_rst_d, busy_d, done_d, err_d;

    // Next-state, datapath and output decode; outputs are registered from state_d
    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        remain_d   = remain_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        addr_d     = imem_addr;
        wdata_d    = imem_wdata;
        len_word   = {len_hi_q, in_data};
        xfer       = in_valid & in_ready;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN_HI;
                    addr_d     = '0;
                    byte_cnt_d = '0;
                    remain_d   = '0;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = in_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_word == '0) begin
                        state_d = S_DONE;
                    end else if (32'(len_word) > DEPTH) begin
                        state_d = S_ERR;
                    end else begin
                        remain_d = len_word;
                        state_d  = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_d     = {word_q[15:0], in_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wdata_d = {word_q, in_data};
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // Address stays on the last word rather than stepping past the top
                if (remain_q > CNT_W'(1)) begin
                    addr_d   = imem_addr + ADDR_W'(4);
                    remain_d = remain_q - CNT_W'(1);
                    state_d  = S_DATA;
                end else begin
                    remain_d = '0;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) || (state_d == S_DATA);
        busy_d     = in_ready_d || (state_d == S_WRITE);
        imem_we_d  = (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
        cpu_rst_d  = (state_d == S_DONE);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_hi_q   <= '0;
            remain_q   <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_rst    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            remain_q   <= remain_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            imem_addr  <= addr_d;
            imem_wdata <= wdata_d;
            in_ready   <= in_ready_d;
            imem_we    <= imem_we_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
            cpu_rst    <= cpu_rst_d;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: byte streams are replayed and the captured memory
// writes are compared with a list derived directly from the stream contents.
module tb_instr_loader;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1 << (ADDR_W - 2);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  stream_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int          exp_n;
    bit          exp_err;

    instr_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Capture every write strobe seen between clock edges
    always @(negedge clk) begin
        if (imem_we === 1'b1) got_q.push_back(64'({imem_addr, imem_wdata}));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: count is the first two bytes; each following 4 bytes form one word at 4*i
    task automatic model_load();
        logic [31:0] w;
        exp_q.delete();
        exp_n   = int'({stream_q[0], stream_q[1]});
        exp_err = (exp_n > int'(DEPTH));
        if (!exp_err) begin
            for (int i = 0; i < exp_n; i++) begin
                w = {stream_q[2+4*i], stream_q[3+4*i], stream_q[4+4*i], stream_q[5+4*i]};
                exp_q.push_back(64'({ADDR_W'(4*i), w}));
            end
        end
    endtask

    task automatic build_stream(input int n, input int nwords);
        stream_q.delete();
        stream_q.push_back(8'(n >> 8));
        stream_q.push_back(8'(n));
        for (int i = 0; i < 4*nwords; i++) stream_q.push_back(8'($urandom));
    endtask

    // Presents one byte, optionally after idle gaps; returns at the negedge after the handshake
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int wait_cnt;
        if (gaps) begin
            repeat (($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 2)) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        wait_cnt = 0;
        while (in_ready !== 1'b1 && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (wait_cnt >= 50) check("byte_timeout", 64'(0), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        check({tag, "_we"},       64'(imem_we),  64'(0));
        check({tag, "_busy"},     64'(busy),     64'(0));
        check({tag, "_done"},     64'(done),     64'(0));
        check({tag, "_err"},      64'(err),      64'(0));
        check({tag, "_cpu_rst"},  64'(cpu_rst),  64'(0));
        check({tag, "_addr"},     64'(imem_addr), 64'(0));
        check({tag, "_wdata"},    64'(imem_wdata), 64'(0));
    endtask

    task automatic run_load(input bit gaps, input int start_at);
        int budget;
        int n_cmp;
        model_load();
        got_q.delete();
        pulse_start();
        check("start_busy", 64'(busy), 64'(1));
        check("start_cpu_rst", 64'(cpu_rst), 64'(0));
        send_byte(stream_q[0], gaps);
        send_byte(stream_q[1], gaps);
        if (exp_n == 0)   check("len0_done", 64'(done), 64'(1));
        else if (exp_err) check("len_err", 64'(err), 64'(1));
        else              check("len_busy", 64'(busy), 64'(1));
        if (!exp_err) begin
            for (int k = 0; k < 4*exp_n; k++) begin
                send_byte(stream_q[2+k], gaps);
                if (k % 4 == 3) begin
                    check("wr_latency_we", 64'(imem_we), 64'(1));
                    check("wr_in_ready", 64'(in_ready), 64'(0));
                end
                if (k == start_at) begin
                    pulse_start();
                    check("start_ignored_busy", 64'(busy), 64'(1));
                end
            end
        end
        budget = 0;
        while (!(done === 1'b1 || err === 1'b1) && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("end_done", 64'(done), 64'(!exp_err));
        check("end_err", 64'(err), 64'(exp_err));
        check("end_cpu_rst", 64'(cpu_rst), 64'(!exp_err));
        check("end_busy", 64'(busy), 64'(0));
        repeat (2) @(negedge clk);
        check("write_count", 64'(got_q.size()), 64'(exp_q.size()));
        n_cmp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n_cmp; i++) check("write_addr_data", got_q[i], exp_q[i]);
        check("end_addr", 64'(imem_addr),
              64'((exp_n > 0 && !exp_err) ? 4*(exp_n-1) : 0));
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start_cpu_rst", 64'(cpu_rst), 64'(0));

        // Two-word directed program
        stream_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
        run_load(1'b0, -1);
        if (got_q.size() == 2) begin
            check("dir_word0", got_q[0], 64'({ADDR_W'(0), 32'h20080005}));
            check("dir_word1", got_q[1], 64'({ADDR_W'(4), 32'hAC080000}));
        end else begin
            check("dir_count", 64'(got_q.size()), 64'(2));
        end

        // Zero-length load
        build_stream(0, 0);
        run_load(1'b1, -1);

        // Oversized count then recovery
        build_stream(257, 0);
        run_load(1'b0, -1);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (4) @(negedge clk);
        check("err_in_ready", 64'(in_ready), 64'(0));
        check("err_hold", 64'(err), 64'(1));
        check("err_no_write", 64'(got_q.size()), 64'(0));
        in_valid = 1'b0;
        build_stream(3, 3);
        run_load(1'b1, -1);

        // Full-depth load with stalls
        build_stream(int'(DEPTH), int'(DEPTH));
        run_load(1'b1, -1);

        // Start pulsed mid-word during DATA
        build_stream(6, 6);
        run_load(1'b1, 9);

        repeat (4) begin
            int n;
            n = $urandom_range(1, 10);
            build_stream(n, n);
            run_load(1'($urandom_range(0, 1)), -1);
        end

        // Reset after two bytes of the third word
        build_stream(5, 5);
        got_q.delete();
        pulse_start();
        for (int k = 0; k < 2 + 10; k++) send_byte(stream_q[k], 1'b0);
        check("pre_reset_writes", 64'(got_q.size()), 64'(2));
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        got_q.delete();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        check_reset_outputs("post_reset_idle");
        check("post_reset_no_write", 64'(got_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
